dsp_pipe_chain: RTL and testbench
=================================

Name: dsp_pipe_chain

Overview:
- Parametrised successor to the single-stage register/bypass mux used on DSP48A1 operand and result paths.
- Carries LANES independent data lanes through a chain of up to DEPTH register stages, with a runtime-selectable tap (latency 0..DEPTH).
- Tracks a valid bit per stage and supports global stall (ce), synchronous clear, and glitch-free latency reload.
- Sits between the operand input ports and the pre-adder/multiplier stages; latency is set by configuration registers instead of fixed per instance.

Parameters:
WIDTH, 18, bits per lane
LANES, 2, number of parallel lanes sharing control
DEPTH, 4, maximum register stages (1..8)
LAT_W, 3, width of latency select; must satisfy 2^LAT_W > DEPTH
LAT_INIT, 1, latency after reset

Ports:
clk  input  1  clock, all flops rising-edge
rst_n  input  1  asynchronous active-low reset
ce  input  1  global clock enable; 0 = whole chain holds
clr  input  1  synchronous clear of data and valid, active-high, ignores ce
in_valid  input  1  qualifies in_data this cycle
in_data  input  LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
lat_sel  input  LAT_W  requested latency 0..DEPTH
lat_ld  input  1  single-cycle pulse: load lat_sel
out_valid  output  1  valid at selected tap
out_data  output  LANES*WIDTH  data at selected tap
lat_cur  output  LAT_W  latency currently in effect
busy  output  1  high while the chain holds any valid stage

Behaviour:
- Reset (rst_n=0, asynchronous): all stage data = 0, all stage valids = 0, lat_cur = LAT_INIT.
- Output values during reset: out_valid = 0. busy = 0. out_data = 0 if LAT_INIT>0; equals in_data if LAT_INIT=0.
- Stage 1 captures {in_valid, in_data}; stage k captures stage k-1. Update occurs only on a clock edge with ce=1 and clr=0.
- ce=0: all stage data and valids hold. The tap mux is still live, so a latency-0 path still passes input.
- Tap selection:
  - lat_cur=0: out_data = in_data and out_valid = in_valid, combinationally (bypass).
  - lat_cur=k (k≥1): outputs driven from stage k. Latency = k enabled (ce=1) cycles.
- Stages beyond lat_cur still shift and are ignored. They do not contribute to busy.
- lat_ld=1 on an edge (ce-independent):
  - lat_cur <= lat_sel, saturated to DEPTH if lat_sel > DEPTH.
  - All stage valids are cleared on the same edge. Data registers are untouched.
  - Consequence: the first valid output under the new latency appears exactly lat_cur enabled cycles after the next accepted in_valid. No stale sample is re-emitted.
- clr=1: all stage data and valids go to 0 on that edge. lat_cur is unchanged.
- Priority on a single edge: rst_n > clr > lat_ld > ce shift.
  - clr and lat_ld together: clear the chain and load the latency.
  - lat_ld together with ce shift: the shift is suppressed for valids (all cleared). Data still shifts if ce=1.
- busy = OR of valid bits of stages 1..lat_cur. busy = 0 when lat_cur = 0.
- Lanes are fully independent in data. All control signals are shared across lanes.
- No arithmetic is performed. Data passes bit-exact.

Optional Feature:
- Macro: DSP_PIPE_PARITY_EN.
- When defined:
  - Each stage stores one even-parity bit per lane, computed on in_data at entry.
  - New output par_err, 1 bit, registered, reset 0.
  - par_err is set for one cycle when out_valid=1 and any lane's recomputed parity at the tap mismatches the stored bit.
  - Bypass (lat_cur=0) never flags.
- When undefined: no parity storage, no par_err port.

Test Plan:
- Reset: assert rst_n=0 mid-stream with LAT_INIT=1 → out_valid=0, out_data=0, lat_cur=1 immediately, without waiting for a clock edge.
- Latency 3, ce=1: in_data lane0=0x00AAA, lane1=0x15555 with in_valid=1 at cycle 0 → same values with out_valid=1 at cycle 3, and out_valid=0 at cycles 1–2.
- Bypass: lat_ld with lat_sel=0, then in_data=0x3FFFF, in_valid=1 → out_data=0x3FFFF in the same cycle, busy=0.
- Stall: latency 2, valid word 0x12345 at cycle 0, ce=0 for cycles 1–3 → output appears at cycle 5; stage contents unchanged during the stall.
- Reload mid-stream: valids in stages 1–2 at latency 4, then lat_ld with lat_sel=7 (DEPTH=4) → lat_cur=4, busy=0 next cycle, no out_valid until 4 cycles after the next in_valid.
- Simultaneous clr and lat_ld: lat_sel=2 → chain zeroed, lat_cur=2, out_data=0, out_valid=0.

Source files
------------

// File: rtl/dsp_pipe_chain_if.sv
// Operand-path bundle for dsp_pipe_chain: stream in, tapped stream out,
// plus latency configuration and status. The slave modport is the pipe
// itself; the master modport is whatever feeds and observes it.
// par_err exists only when DSP_PIPE_PARITY_EN is defined.
interface dsp_pipe_chain_if #(
  parameter int WIDTH = 18,
  parameter int LANES = 2,
  parameter int LAT_W = 3
);
  logic                   ce;
  logic                   clr;
  logic                   in_valid;
  logic [LANES*WIDTH-1:0] in_data;
  logic [LAT_W-1:0]       lat_sel;
  logic                   lat_ld;
  logic                   out_valid;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LAT_W-1:0]       lat_cur;
  logic                   busy;
`ifdef DSP_PIPE_PARITY_EN
  logic                   par_err;
`endif

  modport master (
    output ce, clr, in_valid, in_data, lat_sel, lat_ld,
`ifdef DSP_PIPE_PARITY_EN
    input  par_err,
`endif
    input  out_valid, out_data, lat_cur, busy
  );

  modport slave (
    input  ce, clr, in_valid, in_data, lat_sel, lat_ld,
`ifdef DSP_PIPE_PARITY_EN
    output par_err,
`endif
    output out_valid, out_data, lat_cur, busy
  );
endinterface

// File: rtl/dsp_pipe_chain.sv
// dsp_pipe_chain: LANES-wide register chain of up to DEPTH stages with a
// runtime-selected output tap (latency 0..DEPTH), per-stage valid tracking,
// global stall (ce), synchronous clear and glitch-free latency reload.
// Data passes bit-exact; no arithmetic is done on the lanes.
// Optional feature macro: DSP_PIPE_PARITY_EN (per-lane even parity carried
// alongside each stage, checked at the tap, reported on par_err).
module dsp_pipe_chain #(
  parameter int WIDTH    = 18,
  parameter int LANES    = 2,
  parameter int DEPTH    = 4,
  parameter int LAT_W    = 3,
  parameter int LAT_INIT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  dsp_pipe_chain_if.slave bus
);
  localparam int DW = LANES * WIDTH;

  logic [DW-1:0]    data_p [1:DEPTH];
  logic [DEPTH:1]   vld_p;
  logic [LAT_W-1:0] lat_cur_q;

  // Requests beyond the physical chain length clamp to the deepest tap.
  function automatic logic [LAT_W-1:0] sat_lat(input logic [LAT_W-1:0] sel);
    if (int'(sel) > DEPTH) return LAT_W'(DEPTH);
    return sel;
  endfunction

`ifdef DSP_PIPE_PARITY_EN
  logic [LANES-1:0] par_p [1:DEPTH];
  logic [LANES-1:0] tap_par;
  logic             par_err_q;

  // One even-parity bit per lane: XOR of the lane's bits.
  function automatic logic [LANES-1:0] lane_parity(input logic [DW-1:0] d);
    logic [LANES-1:0] p;
    for (int l = 0; l < LANES; l++) p[l] = ^d[l*WIDTH +: WIDTH];
    return p;
  endfunction
`endif

  // Stage data: reset/clear to zero, otherwise shift when enabled.
  // lat_ld deliberately does not touch data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        data_p[k] <= '0;
`ifdef DSP_PIPE_PARITY_EN
        par_p[k]  <= '0;
`endif
      end
    end else if (bus.clr) begin
      for (int k = 1; k <= DEPTH; k++) begin
        data_p[k] <= '0;
`ifdef DSP_PIPE_PARITY_EN
        par_p[k]  <= '0;
`endif
      end
    end else if (bus.ce) begin
      data_p[1] <= bus.in_data;
`ifdef DSP_PIPE_PARITY_EN
      par_p[1]  <= lane_parity(bus.in_data);
`endif
      for (int k = 2; k <= DEPTH; k++) begin
        data_p[k] <= data_p[k-1];
`ifdef DSP_PIPE_PARITY_EN
        par_p[k]  <= par_p[k-1];
`endif
      end
    end
  end

  // Stage valids: a reload flushes them so no stale sample appears at the
  // new tap; otherwise they shift with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (bus.clr || bus.lat_ld) begin
      vld_p <= '0;
    end else if (bus.ce) begin
      vld_p[1] <= bus.in_valid;
      for (int k = 2; k <= DEPTH; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  // Latency register: loads on lat_ld regardless of ce or clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lat_cur_q <= LAT_W'(LAT_INIT);
    else if (bus.lat_ld) lat_cur_q <= sat_lat(bus.lat_sel);
  end

  // Tap mux and busy: latency 0 bypasses the chain combinationally; only
  // stages up to the active tap count toward busy.
  always_comb begin
    bus.out_data  = bus.in_data;
    bus.out_valid = bus.in_valid & rst_n;
    bus.busy      = 1'b0;
`ifdef DSP_PIPE_PARITY_EN
    tap_par       = lane_parity(bus.in_data);
`endif
    for (int k = 1; k <= DEPTH; k++) begin
      if (int'(lat_cur_q) == k) begin
        bus.out_data  = data_p[k];
        bus.out_valid = vld_p[k];
`ifdef DSP_PIPE_PARITY_EN
        tap_par       = par_p[k];
`endif
      end
      if (k <= int'(lat_cur_q)) bus.busy = bus.busy | vld_p[k];
    end
  end

  assign bus.lat_cur = lat_cur_q;

`ifdef DSP_PIPE_PARITY_EN
  // Parity check at the tap, registered; bypass never flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else par_err_q <= bus.out_valid && (lat_cur_q != '0) &&
                      (lane_parity(bus.out_data) != tap_par);
  end

  assign bus.par_err = par_err_q;
`endif

endmodule

// File: tb/tb_dsp_pipe_chain.sv
// Directed bench for dsp_pipe_chain (WIDTH=18, LANES=2, DEPTH=4, LAT_INIT=1).
// Inputs change 1 ns after a rising edge and outputs are checked there.
module tb_dsp_pipe_chain;
  localparam int WIDTH = 18;
  localparam int LANES = 2;
  localparam int DEPTH = 4;
  localparam int LAT_W = 3;
  localparam int DW    = WIDTH * LANES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  dsp_pipe_chain_if #(.WIDTH(WIDTH), .LANES(LANES), .LAT_W(LAT_W)) bus ();

  dsp_pipe_chain #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH),
                   .LAT_W(LAT_W), .LAT_INIT(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_lat(input logic [LAT_W-1:0] sel);
    bus.lat_sel = sel;
    bus.lat_ld  = 1'b1;
    tick();
    bus.lat_ld  = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    d = {18'h0F0F0, 18'h01234};
    bus.ce = 1'b1; bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.lat_sel = '0; bus.lat_ld = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = d;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== d) begin
      failures++;
      $display("FAIL pre_reset_stream got v=%b d=%h exp v=1 d=%h", bus.out_valid, bus.out_data, d);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      failures++;
      $display("FAIL async_reset_out got v=%b d=%h exp v=0 d=0", bus.out_valid, bus.out_data);
    end
    checks++;
    if (bus.lat_cur !== 3'd1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_ctl got lat=%0d busy=%b exp lat=1 busy=0", bus.lat_cur, bus.busy);
    end
    bus.in_valid = 1'b0; bus.in_data = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency3();
    logic [DW-1:0] d;
    d = {18'h15555, 18'h00AAA};
    load_lat(3'd3);
    checks++;
    if (bus.lat_cur !== 3'd3) begin
      failures++;
      $display("FAIL lat3_load got %0d exp 3", bus.lat_cur);
    end
    bus.in_valid = 1'b1; bus.in_data = d;
    tick();
    bus.in_valid = 1'b0; bus.in_data = '0;
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL lat3_early_c%0d got v=%b exp v=0", c, bus.out_valid);
      end
      tick();
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== d) begin
      failures++;
      $display("FAIL lat3_out got v=%b d=%h exp v=1 d=%h", bus.out_valid, bus.out_data, d);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat3_after got v=%b exp v=0", bus.out_valid);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] d;
    d = {18'h3FFFF, 18'h3FFFF};
    load_lat(3'd0);
    bus.in_valid = 1'b1; bus.in_data = d;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== d || bus.busy !== 1'b0 || bus.lat_cur !== 3'd0) begin
      failures++;
      $display("FAIL bypass got v=%b d=%h busy=%b lat=%0d exp v=1 d=%h busy=0 lat=0",
               bus.out_valid, bus.out_data, bus.busy, bus.lat_cur, d);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL bypass_busy got %b exp 0", bus.busy);
    end
    bus.in_valid = 1'b0; bus.in_data = '0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      failures++;
      $display("FAIL bypass_idle got v=%b d=%h exp v=0 d=0", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] d;
    d = {18'h12345, 18'h12345};
    load_lat(3'd2);
    bus.in_valid = 1'b1; bus.in_data = d;
    tick();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.ce = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold_c%0d got v=%b busy=%b exp v=0 busy=1", c, bus.out_valid, bus.busy);
      end
    end
    bus.ce = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== d) begin
      failures++;
      $display("FAIL stall_out got v=%b d=%h exp v=1 d=%h", bus.out_valid, bus.out_data, d);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_after got v=%b exp v=0", bus.out_valid);
    end
  endtask

  task automatic test_reload();
    logic [DW-1:0] d;
    d = {18'h2A5A5, 18'h05A5A};
    load_lat(3'd4);
    bus.in_valid = 1'b1; bus.in_data = {18'h00011, 18'h00022};
    tick();
    bus.in_data = {18'h00033, 18'h00044};
    tick();
    bus.in_valid = 1'b0; bus.in_data = '0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL reload_busy_before got %b exp 1", bus.busy);
    end
    load_lat(3'd7);
    checks++;
    if (bus.lat_cur !== 3'd4 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reload_sat got lat=%0d busy=%b exp lat=4 busy=0", bus.lat_cur, bus.busy);
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reload_stale_c%0d got v=%b exp v=0", c, bus.out_valid);
      end
    end
    bus.in_valid = 1'b1; bus.in_data = d;
    tick();
    bus.in_valid = 1'b0; bus.in_data = '0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reload_early_c%0d got v=%b exp v=0", c, bus.out_valid);
      end
      tick();
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== d) begin
      failures++;
      $display("FAIL reload_out got v=%b d=%h exp v=1 d=%h", bus.out_valid, bus.out_data, d);
    end
  endtask

  task automatic test_clr_ld();
    load_lat(3'd3);
    bus.in_valid = 1'b1; bus.in_data = {18'h3C3C3, 18'h1E1E1};
    tick(); tick(); tick();
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.clr = 1'b1; bus.lat_ld = 1'b1; bus.lat_sel = 3'd2;
    tick();
    bus.clr = 1'b0; bus.lat_ld = 1'b0;
    checks++;
    if (bus.lat_cur !== 3'd2 || bus.out_data !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_ld got lat=%0d d=%h v=%b busy=%b exp lat=2 d=0 v=0 busy=0",
               bus.lat_cur, bus.out_data, bus.out_valid, bus.busy);
    end
    bus.in_valid = 1'b1; bus.in_data = {18'h00101, 18'h00202};
    tick();
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    checks++;
    if (bus.lat_cur !== 3'd2 || bus.busy !== 1'b0 || bus.out_data !== '0) begin
      failures++;
      $display("FAIL clr_only got lat=%0d busy=%b d=%h exp lat=2 busy=0 d=0",
               bus.lat_cur, bus.busy, bus.out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v [3];
    v[0] = {18'h00001, 18'h3FFFE};
    v[1] = {18'h20000, 18'h1FFFF};
    v[2] = {18'h0ABCD, 18'h35432};
    load_lat(3'd1);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = v[i];
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== v[i]) begin
        failures++;
        $display("FAIL b2b_%0d got v=%b d=%h exp v=1 d=%h", i, bus.out_valid, bus.out_data, v[i]);
      end
    end
    bus.in_valid = 1'b0; bus.in_data = '0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_latency3();
    test_bypass();
    test_stall();
    test_reload();
    test_clr_ld();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
